// File: rtl/axi_txn_limiter_pkg.sv
// rtl/axi_txn_limiter_pkg.sv - AXI4+ATOP channel structs and ATOP field index used by the limiter
package axi_txn_limiter_pkg;

  localparam int unsigned ATOP_R_RESP = 5;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [5:0]  atop;
  } aw_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_resp_t;

endpackage

// File: rtl/axi_txn_limiter_cnt.sv
// rtl/axi_txn_limiter_cnt.sv - outstanding-transaction counter, +0/1/2 and -1 per cycle
// below_one_o lets the caller reserve a slot for a same-cycle increment.
module axi_txn_limiter_cnt #(
  parameter int unsigned Max = 8,
  localparam int unsigned Width = $clog2(Max + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       inc_i,
  input  logic             dec_i,
  output logic [Width-1:0] cnt_o,
  output logic             below_o,
  output logic             below_one_o
);

  localparam logic [Width:0] MaxW = (Width + 1)'(Max);

  logic [Width-1:0] cnt_q, cnt_d;
  logic [Width:0]   sum;
  logic             underflow;

  always_comb begin
    underflow = dec_i && (cnt_q == '0);
    sum = (Width + 1)'(cnt_q) + (Width + 1)'(inc_i);
    // A decrement at zero is a protocol error; it is dropped so the count holds.
    if (dec_i && !underflow) begin
      sum = sum - (Width + 1)'(1);
    end
    cnt_d = Width'(sum);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign below_o     = (Width + 1)'(cnt_q) < MaxW;
  assign below_one_o = ((Width + 1)'(cnt_q) + (Width + 1)'(1)) < MaxW;

`ifndef SYNTHESIS
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !(dec_i && (cnt_q == '0)));
`endif

endmodule

// File: rtl/axi_txn_limiter.sv
// rtl/axi_txn_limiter.sv - bounds outstanding AXI writes/reads, with drain/idle handshake
// Optional saturating stall counter output under AXI_TXN_LIMITER_STATS_EN.
module axi_txn_limiter
  import axi_txn_limiter_pkg::*;
#(
  parameter int unsigned MaxWrTxns = 8,
  parameter int unsigned MaxRdTxns = 8,
  parameter type req_t = axi_req_t,
  parameter type resp_t = axi_resp_t,
  localparam int unsigned WrCntWidth = $clog2(MaxWrTxns + 1),
  localparam int unsigned RdCntWidth = $clog2(MaxRdTxns + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  req_t                  slv_req_i,
  output resp_t                 slv_resp_o,
  output req_t                  mst_req_o,
  input  resp_t                 mst_resp_i,
  input  logic                  drain_i,
  output logic                  idle_o,
  output logic [WrCntWidth-1:0] wr_cnt_o,
  output logic [RdCntWidth-1:0] rd_cnt_o
`ifdef AXI_TXN_LIMITER_STATS_EN
  ,
  output logic [31:0]           stall_cnt_o
`endif
);

  typedef enum logic [1:0] {StRun, StDrain, StIdle} state_e;

  state_e state_q, state_d;

  logic                  run;
  logic                  wr_below, rd_below, rd_below_one;
  logic                  atop_r, ar_req, rd_room, aw_lim_ok, aw_ok, ar_ok;
  logic                  aw_fire, ar_fire, b_fire, r_last_fire;
  logic [1:0]            rd_inc;
  logic [WrCntWidth-1:0] wr_cnt;
  logic [RdCntWidth-1:0] rd_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (drain_i) state_d = StDrain;
      StDrain: begin
        if (!drain_i) begin
          state_d = StRun;
        end else if ((wr_cnt == '0) && (rd_cnt == '0)) begin
          state_d = StIdle;
        end
      end
      StIdle:  if (!drain_i) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    run    = (state_q == StRun);
    idle_o = (state_q == StIdle);
  end

  // AR priority is decided on the presented AR rather than its handshake,
  // so no gated valid ever depends on a downstream ready.
  always_comb begin
    atop_r    = slv_req_i.aw.atop[ATOP_R_RESP];
    ar_ok     = run & rd_below;
    ar_req    = slv_req_i.ar_valid & ar_ok;
    rd_room   = ar_req ? rd_below_one : rd_below;
    aw_lim_ok = wr_below & (~atop_r | rd_room);
    aw_ok     = run & aw_lim_ok;
  end

  always_comb begin
    mst_req_o           = slv_req_i;
    slv_resp_o          = mst_resp_i;
    mst_req_o.aw_valid  = slv_req_i.aw_valid & aw_ok;
    mst_req_o.ar_valid  = slv_req_i.ar_valid & ar_ok;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_ok;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_ok;
    if (rst_i) begin
      mst_req_o.aw_valid  = 1'b0;
      mst_req_o.w_valid   = 1'b0;
      mst_req_o.ar_valid  = 1'b0;
      mst_req_o.b_ready   = 1'b0;
      mst_req_o.r_ready   = 1'b0;
      slv_resp_o.aw_ready = 1'b0;
      slv_resp_o.w_ready  = 1'b0;
      slv_resp_o.ar_ready = 1'b0;
      slv_resp_o.b_valid  = 1'b0;
      slv_resp_o.r_valid  = 1'b0;
    end
  end

  always_comb begin
    aw_fire     = slv_req_i.aw_valid & aw_ok & mst_resp_i.aw_ready;
    ar_fire     = slv_req_i.ar_valid & ar_ok & mst_resp_i.ar_ready;
    b_fire      = mst_resp_i.b_valid & slv_req_i.b_ready;
    r_last_fire = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
    rd_inc      = 2'(ar_fire) + 2'(aw_fire & atop_r);
  end

  axi_txn_limiter_cnt #(
    .Max (MaxWrTxns)
  ) i_wr_cnt (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .inc_i       ({1'b0, aw_fire}),
    .dec_i       (b_fire),
    .cnt_o       (wr_cnt),
    .below_o     (wr_below),
    .below_one_o ()
  );

  axi_txn_limiter_cnt #(
    .Max (MaxRdTxns)
  ) i_rd_cnt (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .inc_i       (rd_inc),
    .dec_i       (r_last_fire),
    .cnt_o       (rd_cnt),
    .below_o     (rd_below),
    .below_one_o (rd_below_one)
  );

  assign wr_cnt_o = wr_cnt;
  assign rd_cnt_o = rd_cnt;

`ifdef AXI_TXN_LIMITER_STATS_EN
  logic [31:0] stall_q, stall_d;
  logic        stall_hit;

  always_comb begin
    stall_hit = run & ((slv_req_i.aw_valid & ~aw_lim_ok) | (slv_req_i.ar_valid & ~rd_below));
    stall_d   = stall_q;
    if (stall_hit && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_axi_txn_limiter.sv
// tb/tb_axi_txn_limiter.sv - randomized self-checking bench for axi_txn_limiter
module tb_axi_txn_limiter;
  import axi_txn_limiter_pkg::*;

  localparam int MAXW = 2;
  localparam int MAXR = 4;
  localparam int M_RUN = 0, M_DRAIN = 1, M_IDLE = 2;

  logic      clk = 1'b0;
  logic      rst;
  axi_req_t  slv_req, mst_req;
  axi_resp_t slv_resp, mst_resp;
  logic      drain, idle;
  logic [1:0] wr_cnt;
  logic [2:0] rd_cnt;
`ifdef AXI_TXN_LIMITER_STATS_EN
  logic [31:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: one queue entry per outstanding transaction; reads hold remaining beats.
  int wq[$];
  int rq[$];
  int m_state;
  int unsigned m_stall;
  bit exp_awv, exp_arv, exp_awr, exp_arr, exp_idle, exp_stall_hit;
  int exp_wr, exp_rd;

  axi_txn_limiter #(
    .MaxWrTxns (MAXW),
    .MaxRdTxns (MAXR),
    .req_t     (axi_req_t),
    .resp_t    (axi_resp_t)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp),
    .mst_req_o  (mst_req),
    .mst_resp_i (mst_resp),
    .drain_i    (drain),
    .idle_o     (idle),
    .wr_cnt_o   (wr_cnt),
    .rd_cnt_o   (rd_cnt)
`ifdef AXI_TXN_LIMITER_STATS_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    slv_req  = '0;
    mst_resp = '0;
    drain    = 1'b0;
  endtask

  task automatic model_reset();
    wq.delete();
    rq.delete();
    m_state = M_RUN;
    m_stall = 0;
  endtask

  task automatic settle();
    bit run, ar_ok, aw_ok, atop;
    mst_resp.r.last = (rq.size() > 0) && (rq[0] == 1);
    #1;
    run   = (m_state == M_RUN);
    atop  = slv_req.aw.atop[ATOP_R_RESP];
    ar_ok = run && (rq.size() < MAXR);
    aw_ok = run && (wq.size() < MAXW) &&
            (!atop || (rq.size() + int'(slv_req.ar_valid && ar_ok)) < MAXR);
    exp_awv  = slv_req.aw_valid && aw_ok;
    exp_awr  = mst_resp.aw_ready && aw_ok;
    exp_arv  = slv_req.ar_valid && ar_ok;
    exp_arr  = mst_resp.ar_ready && ar_ok;
    exp_wr   = wq.size();
    exp_rd   = rq.size();
    exp_idle = (m_state == M_IDLE);
    exp_stall_hit = run && ((slv_req.aw_valid && !aw_ok) || (slv_req.ar_valid && !ar_ok));
  endtask

  task automatic advance();
    int nw, nr, aw_beats, ar_beats;
    bit aw_hs, ar_hs, b_hs, r_hs, atop;
    nw = wq.size();
    nr = rq.size();
    aw_hs = exp_awv && mst_resp.aw_ready;
    ar_hs = exp_arv && mst_resp.ar_ready;
    b_hs  = mst_resp.b_valid && slv_req.b_ready;
    r_hs  = mst_resp.r_valid && slv_req.r_ready;
    atop  = slv_req.aw.atop[ATOP_R_RESP];
    aw_beats = int'(slv_req.aw.len) + 1;
    ar_beats = int'(slv_req.ar.len) + 1;
    @(posedge clk);
    case (m_state)
      M_RUN:   if (drain) m_state = M_DRAIN;
      M_DRAIN: if (!drain) m_state = M_RUN; else if (nw == 0 && nr == 0) m_state = M_IDLE;
      default: if (!drain) m_state = M_RUN;
    endcase
    if (b_hs && wq.size() > 0) void'(wq.pop_front());
    if (r_hs && rq.size() > 0) begin
      rq[0] = rq[0] - 1;
      if (rq[0] == 0) void'(rq.pop_front());
    end
    if (aw_hs) begin
      wq.push_back(1);
      if (atop) rq.push_back(aw_beats);
    end
    if (ar_hs) rq.push_back(ar_beats);
    if (exp_stall_hit && m_stall != 32'hFFFF_FFFF) m_stall++;
    #1;
  endtask

  task automatic flush();
    clear_inputs();
    for (int i = 0; i < 64 && (wq.size() > 0 || rq.size() > 0); i++) begin
      slv_req.b_ready  = 1'b1;
      slv_req.r_ready  = 1'b1;
      mst_resp.b_valid = wq.size() > 0;
      mst_resp.r_valid = rq.size() > 0;
      settle();
      advance();
    end
    clear_inputs();
    settle();
    advance();
  endtask

  task automatic test_reset();
    slv_req.aw_valid = 1'b1; slv_req.ar_valid = 1'b1; slv_req.w_valid = 1'b1;
    mst_resp.aw_ready = 1'b1; mst_resp.ar_ready = 1'b1; mst_resp.w_ready = 1'b1;
    mst_resp.b_valid = 1'b1; mst_resp.r_valid = 1'b1;
    #1;
    n_cmp++;
    if ({mst_req.aw_valid, mst_req.ar_valid, mst_req.w_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_dn_valids: got %b want 000", {mst_req.aw_valid, mst_req.ar_valid, mst_req.w_valid});
    end
    n_cmp++;
    if ({slv_resp.aw_ready, slv_resp.ar_ready, slv_resp.w_ready} !== 3'b000) begin
      n_fail++; $display("FAIL reset_up_readies: got %b want 000", {slv_resp.aw_ready, slv_resp.ar_ready, slv_resp.w_ready});
    end
    n_cmp++;
    if ({idle, wr_cnt, rd_cnt} !== 6'd0) begin
      n_fail++; $display("FAIL reset_state: idle %b wr %0d rd %0d, want all 0", idle, wr_cnt, rd_cnt);
    end
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    slv_req.ar_valid = 1'b1; mst_resp.ar_ready = 1'b1;
    settle();
    n_cmp++;
    if ({mst_req.ar_valid, idle} !== {exp_arv, exp_idle}) begin
      n_fail++; $display("FAIL reset_release_run: got arv/idle %b want %b", {mst_req.ar_valid, idle}, {exp_arv, exp_idle});
    end
    advance();
    flush();
  endtask

  task automatic test_wr_limit();
    clear_inputs();
    slv_req.aw_valid = 1'b1; mst_resp.aw_ready = 1'b1; slv_req.w_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_cmp++;
      if ({mst_req.aw_valid, slv_resp.aw_ready} !== {exp_awv, exp_awr}) begin
        n_fail++; $display("FAIL wr_limit_aw%0d: got %b want %b", i, {mst_req.aw_valid, slv_resp.aw_ready}, {exp_awv, exp_awr});
      end
      advance();
    end
    settle();
    n_cmp++;
    if ({wr_cnt, mst_req.aw_valid} !== {2'(MAXW), 1'b0}) begin
      n_fail++; $display("FAIL wr_limit_block: wr %0d awv %b, want %0d 0", wr_cnt, mst_req.aw_valid, MAXW);
    end
    mst_resp.b_valid = 1'b1; slv_req.b_ready = 1'b1;
    settle();
    advance();
    mst_resp.b_valid = 1'b0;
    settle();
    n_cmp++;
    if (mst_req.aw_valid !== 1'b1 || exp_awv !== 1'b1) begin
      n_fail++; $display("FAIL wr_limit_release: got awv %b want 1", mst_req.aw_valid);
    end
    advance();
    settle();
    n_cmp++;
    if (wr_cnt !== 2'(exp_wr) || exp_wr != MAXW) begin
      n_fail++; $display("FAIL wr_limit_after: got %0d want %0d", wr_cnt, MAXW);
    end
    flush();
  endtask

  task automatic test_rd_burst();
    clear_inputs();
    slv_req.ar_valid = 1'b1; slv_req.ar.len = 8'd3; mst_resp.ar_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      n_cmp++;
      if (mst_req.ar_valid !== exp_arv) begin
        n_fail++; $display("FAIL rd_burst_ar%0d: got %b want %b", i, mst_req.ar_valid, exp_arv);
      end
      advance();
    end
    slv_req.ar_valid = 1'b0;
    slv_req.r_ready = 1'b1; mst_resp.r_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      settle();
      n_cmp++;
      if (rd_cnt !== 3'(exp_rd)) begin
        n_fail++; $display("FAIL rd_burst_cnt beat %0d: got %0d want %0d", k, rd_cnt, exp_rd);
      end
      if (k == 3 || k == 4) begin
        n_cmp++;
        if (rd_cnt !== ((k == 3) ? 3'd4 : 3'd3)) begin
          n_fail++; $display("FAIL rd_burst_last_only beat %0d: got %0d", k, rd_cnt);
        end
      end
      advance();
    end
    flush();
  endtask

  task automatic test_atop_priority();
    clear_inputs();
    slv_req.ar_valid = 1'b1; mst_resp.ar_ready = 1'b1; mst_resp.aw_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin settle(); advance(); end
    slv_req.aw_valid = 1'b1; slv_req.aw.atop = 6'h20;
    settle();
    n_cmp++;
    if ({rd_cnt, mst_req.ar_valid, mst_req.aw_valid} !== {3'd3, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL atop_prio: rd %0d arv %b awv %b, want 3 1 0", rd_cnt, mst_req.ar_valid, mst_req.aw_valid);
    end
    advance();
    slv_req.ar_valid = 1'b0;
    slv_req.r_ready = 1'b1; mst_resp.r_valid = 1'b1;
    settle();
    n_cmp++;
    if ({rd_cnt, mst_req.aw_valid} !== {3'd4, 1'b0}) begin
      n_fail++; $display("FAIL atop_full: rd %0d awv %b, want 4 0", rd_cnt, mst_req.aw_valid);
    end
    advance();
    mst_resp.r_valid = 1'b0;
    settle();
    n_cmp++;
    if (mst_req.aw_valid !== exp_awv || exp_awv !== 1'b1) begin
      n_fail++; $display("FAIL atop_pass: got awv %b want 1", mst_req.aw_valid);
    end
    advance();
    slv_req.aw_valid = 1'b0;
    settle();
    n_cmp++;
    if ({wr_cnt, rd_cnt} !== {2'd1, 3'd4}) begin
      n_fail++; $display("FAIL atop_counts: wr %0d rd %0d, want 1 4", wr_cnt, rd_cnt);
    end
    flush();
  endtask

  task automatic test_same_cycle();
    clear_inputs();
    slv_req.aw_valid = 1'b1; mst_resp.aw_ready = 1'b1;
    settle(); advance();
    mst_resp.b_valid = 1'b1; slv_req.b_ready = 1'b1;
    settle();
    n_cmp++;
    if ({wr_cnt, mst_req.aw_valid} !== {2'd1, 1'b1}) begin
      n_fail++; $display("FAIL same_cycle_pre: wr %0d awv %b, want 1 1", wr_cnt, mst_req.aw_valid);
    end
    advance();
    clear_inputs();
    settle();
    n_cmp++;
    if (wr_cnt !== 2'd1) begin
      n_fail++; $display("FAIL same_cycle_hold: got %0d want 1", wr_cnt);
    end
    flush();
  endtask

  task automatic test_drain();
    int rise;
    clear_inputs();
    slv_req.aw_valid = 1'b1; slv_req.ar_valid = 1'b1;
    mst_resp.aw_ready = 1'b1; mst_resp.ar_ready = 1'b1;
    settle(); advance();
    slv_req.ar_valid = 1'b0;
    settle(); advance();
    slv_req.aw_valid = 1'b0;
    drain = 1'b1;
    settle(); advance();
    slv_req.aw_valid = 1'b1; slv_req.ar_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_cmp++;
      if ({mst_req.aw_valid, mst_req.ar_valid, idle, wr_cnt, rd_cnt} !== {1'b0, 1'b0, 1'b0, 2'd2, 3'd1}) begin
        n_fail++; $display("FAIL drain_block%0d: awv %b arv %b idle %b wr %0d rd %0d", i,
                           mst_req.aw_valid, mst_req.ar_valid, idle, wr_cnt, rd_cnt);
      end
      advance();
    end
    slv_req.b_ready = 1'b1; slv_req.r_ready = 1'b1;
    mst_resp.b_valid = 1'b1;
    settle(); advance(); settle(); advance();
    mst_resp.b_valid = 1'b0; mst_resp.r_valid = 1'b1;
    settle(); advance();
    mst_resp.r_valid = 1'b0;
    rise = -1;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_cmp++;
      if (idle !== exp_idle) begin
        n_fail++; $display("FAIL drain_idle cyc %0d: got %b want %b", i, idle, exp_idle);
      end
      if (idle === 1'b1 && rise < 0) rise = i;
      advance();
    end
    n_cmp++;
    if (rise != 1) begin
      n_fail++; $display("FAIL drain_idle_rise: got cycle %0d want 1", rise);
    end
    drain = 1'b0;
    settle();
    n_cmp++;
    if ({idle, mst_req.ar_valid} !== 2'b10) begin
      n_fail++; $display("FAIL drain_exit_idle: idle/arv %b want 10", {idle, mst_req.ar_valid});
    end
    advance();
    settle();
    n_cmp++;
    if ({idle, mst_req.ar_valid} !== 2'b01) begin
      n_fail++; $display("FAIL drain_exit_run: idle/arv %b want 01", {idle, mst_req.ar_valid});
    end
    advance();
    flush();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      slv_req.aw_valid  = $urandom_range(0, 1);
      slv_req.aw.atop   = ($urandom_range(0, 3) == 0) ? 6'h20 : 6'h00;
      slv_req.aw.len    = 8'($urandom_range(0, 1));
      slv_req.ar_valid  = $urandom_range(0, 1);
      slv_req.ar.len    = 8'($urandom_range(0, 2));
      slv_req.w_valid   = $urandom_range(0, 1);
      slv_req.w.data    = $urandom;
      slv_req.b_ready   = $urandom_range(0, 1);
      slv_req.r_ready   = $urandom_range(0, 1);
      mst_resp.aw_ready = $urandom_range(0, 1);
      mst_resp.ar_ready = $urandom_range(0, 1);
      mst_resp.b_valid  = $urandom_range(0, 1) && wq.size() > 0;
      mst_resp.r_valid  = $urandom_range(0, 1) && rq.size() > 0;
      mst_resp.r.data   = $urandom;
      if ($urandom_range(0, 15) == 0) drain = ~drain;
      settle();
      n_cmp++;
      if ({mst_req.aw_valid, slv_resp.aw_ready, mst_req.ar_valid, slv_resp.ar_ready} !==
          {exp_awv, exp_awr, exp_arv, exp_arr}) begin
        n_fail++; $display("FAIL rnd_gate cyc %0d: got %b want %b", c,
          {mst_req.aw_valid, slv_resp.aw_ready, mst_req.ar_valid, slv_resp.ar_ready},
          {exp_awv, exp_awr, exp_arv, exp_arr});
      end
      n_cmp++;
      if ({wr_cnt, rd_cnt, idle} !== {2'(exp_wr), 3'(exp_rd), exp_idle}) begin
        n_fail++; $display("FAIL rnd_state cyc %0d: wr %0d rd %0d idle %b want %0d %0d %b", c,
                           wr_cnt, rd_cnt, idle, exp_wr, exp_rd, exp_idle);
      end
      n_cmp++;
      if ({mst_req.w_valid, mst_req.w.data, slv_resp.r.data} !== {slv_req.w_valid, slv_req.w.data, mst_resp.r.data}) begin
        n_fail++; $display("FAIL rnd_passthru cyc %0d: w %h r %h want w %h r %h", c,
                           mst_req.w.data, slv_resp.r.data, slv_req.w.data, mst_resp.r.data);
      end
`ifdef AXI_TXN_LIMITER_STATS_EN
      n_cmp++;
      if (stall_cnt !== m_stall) begin
        n_fail++; $display("FAIL rnd_stall cyc %0d: got %0d want %0d", c, stall_cnt, m_stall);
      end
`endif
      advance();
    end
    flush();
  endtask

  task automatic test_async_reset();
    clear_inputs();
    slv_req.ar_valid = 1'b1; slv_req.ar.len = 8'd3; mst_resp.ar_ready = 1'b1;
    slv_req.aw_valid = 1'b1; mst_resp.aw_ready = 1'b1;
    settle(); advance();
    slv_req.ar_valid = 1'b0; slv_req.aw_valid = 1'b0;
    slv_req.r_ready = 1'b1; mst_resp.r_valid = 1'b1;
    settle(); advance();
    slv_req.aw_valid = 1'b1; slv_req.w_valid = 1'b1; slv_req.ar_valid = 1'b1;
    mst_resp.b_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({wr_cnt, rd_cnt} !== 5'd0) begin
      n_fail++; $display("FAIL async_rst_cnt: wr %0d rd %0d want 0 0", wr_cnt, rd_cnt);
    end
    n_cmp++;
    if ({mst_req.aw_valid, mst_req.w_valid, mst_req.ar_valid, slv_resp.aw_ready,
         slv_resp.ar_ready, slv_resp.b_valid, slv_resp.r_valid} !== 7'd0) begin
      n_fail++; $display("FAIL async_rst_hs: got %b want 0000000", {mst_req.aw_valid, mst_req.w_valid,
        mst_req.ar_valid, slv_resp.aw_ready, slv_resp.ar_ready, slv_resp.b_valid, slv_resp.r_valid});
    end
    clear_inputs();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    slv_req.ar_valid = 1'b1; mst_resp.ar_ready = 1'b1;
    settle();
    n_cmp++;
    if ({idle, mst_req.ar_valid, slv_resp.ar_ready} !== 3'b011) begin
      n_fail++; $display("FAIL async_rst_run: got %b want 011", {idle, mst_req.ar_valid, slv_resp.ar_ready});
    end
    advance();
    slv_req.ar_valid = 1'b0;
    settle();
    n_cmp++;
    if (rd_cnt !== 3'd1) begin
      n_fail++; $display("FAIL async_rst_count: got %0d want 1", rd_cnt);
    end
    flush();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_wr_limit();
    test_rd_burst();
    test_atop_priority();
    test_same_cycle();
    test_drain();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
